// File: rtl/rs_alu_queue_pkg.sv
// Shared types for the ALU reservation station.
package rs_alu_queue_pkg;

  localparam int unsigned GPR_SIZE           = 64;
  localparam int unsigned ROB_IDX_SIZE       = 5;
  localparam int unsigned RS_DEFAULT_ENTRIES = 8;
  localparam int unsigned RS_IDX_SIZE        = $clog2(RS_DEFAULT_ENTRIES);

  typedef enum logic [3:0] {
    FuOpAdd, FuOpSub, FuOpAnd, FuOpOrr, FuOpEor,
    FuOpLsl, FuOpLsr, FuOpAsr, FuOpMov, FuOpCmp
  } fu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic                    valid;
    fu_op_t                  op;
    logic                    a_ready;
    logic [GPR_SIZE-1:0]     val_a;
    logic [ROB_IDX_SIZE-1:0] a_tag;
    logic                    b_ready;
    logic [GPR_SIZE-1:0]     val_b;
    logic [ROB_IDX_SIZE-1:0] b_tag;
    logic                    nzcv_ready;
    nzcv_t                   nzcv;
    logic [ROB_IDX_SIZE-1:0] nzcv_tag;
    logic                    set_nzcv;
    logic [ROB_IDX_SIZE-1:0] dst;
  } rs_entry_t;

endpackage

// File: rtl/rs_alu_queue_age_matrix.sv
// Age matrix: age_q[i][j] = 1 means slot i was allocated after slot j.
// Picks the single oldest slot among the request vector.
module rs_age_matrix #(
  parameter int unsigned Entries = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [Entries-1:0] alloc_i,
  input  logic [Entries-1:0] req_i,
  output logic [Entries-1:0] oldest_o
);

  logic [Entries-1:0] age_q [Entries];
  logic [Entries-1:0] age_d [Entries];

  // New allocation becomes younger than everyone; nobody stays younger than it.
  always_comb begin
    for (int unsigned i = 0; i < Entries; i++) age_d[i] = age_q[i];
    for (int unsigned i = 0; i < Entries; i++) begin
      if (alloc_i[i]) begin
        age_d[i] = '1;
        for (int unsigned j = 0; j < Entries; j++) begin
          if (j != i) age_d[j][i] = 1'b0;
        end
      end
    end
  end

  // A requester is oldest when no other requester is older than it.
  always_comb begin
    for (int unsigned i = 0; i < Entries; i++) begin
      oldest_o[i] = req_i[i];
      for (int unsigned j = 0; j < Entries; j++) begin
        if (j != i && req_i[j] && age_q[i][j]) oldest_o[i] = 1'b0;
      end
    end
  end

  // Age state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Entries; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < Entries; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/rs_alu_queue.sv
// ALU reservation station: buffers dispatched ops, snoops the CDB for operands
// and flags, and issues the oldest ready op to the ALU with registered outputs.
module rs_alu_queue
  import rs_alu_queue_pkg::*;
#(
  parameter int unsigned RS_ENTRIES = RS_DEFAULT_ENTRIES
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_dispatch_valid,
  input  fu_op_t                  in_dispatch_fu_op,
  input  logic                    in_dispatch_a_ready,
  input  logic [GPR_SIZE-1:0]     in_dispatch_val_a,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag,
  input  logic                    in_dispatch_b_ready,
  input  logic [GPR_SIZE-1:0]     in_dispatch_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag,
  input  logic                    in_dispatch_nzcv_ready,
  input  nzcv_t                   in_dispatch_nzcv,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag,
  input  logic                    in_dispatch_set_nzcv,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
  input  logic                    in_cdb_valid,
  input  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index,
  input  logic [GPR_SIZE-1:0]     in_cdb_value,
  input  logic                    in_cdb_set_nzcv,
  input  nzcv_t                   in_cdb_nzcv,
  input  logic                    in_fu_ready,
  input  logic                    in_flush,
  output logic                    out_dispatch_ready,
  output logic                    out_fu_start,
  output fu_op_t                  out_fu_op,
  output logic [GPR_SIZE-1:0]     out_fu_val_a,
  output logic [GPR_SIZE-1:0]     out_fu_val_b,
  output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index,
  output logic                    out_fu_set_nzcv,
  output nzcv_t                   out_fu_nzcv
);

  localparam int unsigned IdxW = $clog2(RS_ENTRIES);

  rs_entry_t               ent_q [RS_ENTRIES];
  rs_entry_t               ent_d [RS_ENTRIES];
  rs_entry_t               new_ent;
  logic [RS_ENTRIES-1:0]   rdy, oldest, alloc, valid_d;
  logic [IdxW-1:0]         free_idx;
  logic                    accept, issue;
  logic                    dispatch_ready_q, dispatch_ready_d;
  logic                    fu_start_q, fu_set_nzcv_q;
  fu_op_t                  fu_op_q, sel_op;
  logic [GPR_SIZE-1:0]     fu_val_a_q, fu_val_b_q, sel_val_a, sel_val_b;
  logic [ROB_IDX_SIZE-1:0] fu_dst_q, sel_dst;
  nzcv_t                   fu_nzcv_q, sel_nzcv;
  logic                    sel_set_nzcv;

  rs_age_matrix #(
    .Entries(RS_ENTRIES)
  ) u_age (
    .clk_i   (in_clk),
    .rst_ni  (in_rst_n),
    .alloc_i (alloc),
    .req_i   (rdy),
    .oldest_o(oldest)
  );

  // Readiness from registered state only, so a wakeup issues one edge later.
  always_comb begin
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      rdy[i] = ent_q[i].valid & ent_q[i].a_ready & ent_q[i].b_ready & ent_q[i].nzcv_ready;
    end
  end

  // Lowest-index free slot (descending scan, last hit wins).
  always_comb begin
    free_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IdxW'(i);
    end
  end

  // Handshakes, allocation vector and incoming entry with same-cycle CDB bypass.
  always_comb begin
    accept = in_dispatch_valid & dispatch_ready_q & ~in_flush;
    issue  = in_fu_ready & (|rdy) & ~in_flush;
    alloc  = '0;
    if (accept) alloc[free_idx] = 1'b1;

    new_ent            = '0;
    new_ent.valid      = 1'b1;
    new_ent.op         = in_dispatch_fu_op;
    new_ent.a_ready    = in_dispatch_a_ready;
    new_ent.val_a      = in_dispatch_val_a;
    new_ent.a_tag      = in_dispatch_a_tag;
    new_ent.b_ready    = in_dispatch_b_ready;
    new_ent.val_b      = in_dispatch_val_b;
    new_ent.b_tag      = in_dispatch_b_tag;
    new_ent.nzcv_ready = in_dispatch_nzcv_ready;
    new_ent.nzcv       = in_dispatch_nzcv;
    new_ent.nzcv_tag   = in_dispatch_nzcv_tag;
    new_ent.set_nzcv   = in_dispatch_set_nzcv;
    new_ent.dst        = in_dispatch_dst_rob_index;
    if (in_cdb_valid) begin
      if (!in_dispatch_a_ready && in_dispatch_a_tag == in_cdb_rob_index) begin
        new_ent.a_ready = 1'b1;
        new_ent.val_a   = in_cdb_value;
      end
      if (!in_dispatch_b_ready && in_dispatch_b_tag == in_cdb_rob_index) begin
        new_ent.b_ready = 1'b1;
        new_ent.val_b   = in_cdb_value;
      end
      if (!in_dispatch_nzcv_ready && in_cdb_set_nzcv &&
          in_dispatch_nzcv_tag == in_cdb_rob_index) begin
        new_ent.nzcv_ready = 1'b1;
        new_ent.nzcv       = in_cdb_nzcv;
      end
    end
  end

  // Per-slot next state: wakeup, then issue free, then allocate, flush last.
  always_comb begin
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (in_cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].a_ready && ent_q[i].a_tag == in_cdb_rob_index) begin
          ent_d[i].a_ready = 1'b1;
          ent_d[i].val_a   = in_cdb_value;
        end
        if (!ent_q[i].b_ready && ent_q[i].b_tag == in_cdb_rob_index) begin
          ent_d[i].b_ready = 1'b1;
          ent_d[i].val_b   = in_cdb_value;
        end
        if (!ent_q[i].nzcv_ready && in_cdb_set_nzcv && ent_q[i].nzcv_tag == in_cdb_rob_index) begin
          ent_d[i].nzcv_ready = 1'b1;
          ent_d[i].nzcv       = in_cdb_nzcv;
        end
      end
      if (issue && oldest[i]) ent_d[i].valid = 1'b0;
      if (alloc[i])           ent_d[i] = new_ent;
      if (in_flush)           ent_d[i].valid = 1'b0;
      valid_d[i] = ent_d[i].valid;
    end
    dispatch_ready_d = ~(&valid_d);
  end

  // Field mux for the one-hot oldest ready slot.
  always_comb begin
    sel_op       = FuOpAdd;
    sel_val_a    = '0;
    sel_val_b    = '0;
    sel_dst      = '0;
    sel_set_nzcv = 1'b0;
    sel_nzcv     = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (oldest[i]) begin
        sel_op       = ent_q[i].op;
        sel_val_a    = ent_q[i].val_a;
        sel_val_b    = ent_q[i].val_b;
        sel_dst      = ent_q[i].dst;
        sel_set_nzcv = ent_q[i].set_nzcv;
        sel_nzcv     = ent_q[i].nzcv;
      end
    end
  end

  // Slot storage, dispatch-ready flag and registered issue port.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) ent_q[i] <= '0;
      dispatch_ready_q <= 1'b1;
      fu_start_q       <= 1'b0;
      fu_op_q          <= FuOpAdd;
      fu_val_a_q       <= '0;
      fu_val_b_q       <= '0;
      fu_dst_q         <= '0;
      fu_set_nzcv_q    <= 1'b0;
      fu_nzcv_q        <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) ent_q[i] <= ent_d[i];
      dispatch_ready_q <= dispatch_ready_d;
      fu_start_q       <= issue;
      if (issue) begin
        fu_op_q       <= sel_op;
        fu_val_a_q    <= sel_val_a;
        fu_val_b_q    <= sel_val_b;
        fu_dst_q      <= sel_dst;
        fu_set_nzcv_q <= sel_set_nzcv;
        fu_nzcv_q     <= sel_nzcv;
      end
    end
  end

  assign out_dispatch_ready   = dispatch_ready_q;
  assign out_fu_start         = fu_start_q;
  assign out_fu_op            = fu_op_q;
  assign out_fu_val_a         = fu_val_a_q;
  assign out_fu_val_b         = fu_val_b_q;
  assign out_fu_dst_rob_index = fu_dst_q;
  assign out_fu_set_nzcv      = fu_set_nzcv_q;
  assign out_fu_nzcv          = fu_nzcv_q;

endmodule

// File: tb/tb_rs_alu_queue.sv
// Bench for rs_alu_queue: directed scenarios plus random traffic, checked
// against an in-order queue model of the station.
module tb_rs_alu_queue;
  import rs_alu_queue_pkg::*;

  localparam int RS_N = 8;

  logic                    in_clk = 1'b0;
  logic                    in_rst_n;
  logic                    in_dispatch_valid;
  fu_op_t                  in_dispatch_fu_op;
  logic                    in_dispatch_a_ready;
  logic [GPR_SIZE-1:0]     in_dispatch_val_a;
  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag;
  logic                    in_dispatch_b_ready;
  logic [GPR_SIZE-1:0]     in_dispatch_val_b;
  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag;
  logic                    in_dispatch_nzcv_ready;
  nzcv_t                   in_dispatch_nzcv;
  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag;
  logic                    in_dispatch_set_nzcv;
  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index;
  logic                    in_cdb_valid;
  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index;
  logic [GPR_SIZE-1:0]     in_cdb_value;
  logic                    in_cdb_set_nzcv;
  nzcv_t                   in_cdb_nzcv;
  logic                    in_fu_ready;
  logic                    in_flush;
  logic                    out_dispatch_ready;
  logic                    out_fu_start;
  fu_op_t                  out_fu_op;
  logic [GPR_SIZE-1:0]     out_fu_val_a;
  logic [GPR_SIZE-1:0]     out_fu_val_b;
  logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index;
  logic                    out_fu_set_nzcv;
  nzcv_t                   out_fu_nzcv;

  rs_alu_queue #(.RS_ENTRIES(RS_N)) dut (
    .in_clk                   (in_clk),
    .in_rst_n                 (in_rst_n),
    .in_dispatch_valid        (in_dispatch_valid),
    .in_dispatch_fu_op        (in_dispatch_fu_op),
    .in_dispatch_a_ready      (in_dispatch_a_ready),
    .in_dispatch_val_a        (in_dispatch_val_a),
    .in_dispatch_a_tag        (in_dispatch_a_tag),
    .in_dispatch_b_ready      (in_dispatch_b_ready),
    .in_dispatch_val_b        (in_dispatch_val_b),
    .in_dispatch_b_tag        (in_dispatch_b_tag),
    .in_dispatch_nzcv_ready   (in_dispatch_nzcv_ready),
    .in_dispatch_nzcv         (in_dispatch_nzcv),
    .in_dispatch_nzcv_tag     (in_dispatch_nzcv_tag),
    .in_dispatch_set_nzcv     (in_dispatch_set_nzcv),
    .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
    .in_cdb_valid             (in_cdb_valid),
    .in_cdb_rob_index         (in_cdb_rob_index),
    .in_cdb_value             (in_cdb_value),
    .in_cdb_set_nzcv          (in_cdb_set_nzcv),
    .in_cdb_nzcv              (in_cdb_nzcv),
    .in_fu_ready              (in_fu_ready),
    .in_flush                 (in_flush),
    .out_dispatch_ready       (out_dispatch_ready),
    .out_fu_start             (out_fu_start),
    .out_fu_op                (out_fu_op),
    .out_fu_val_a             (out_fu_val_a),
    .out_fu_val_b             (out_fu_val_b),
    .out_fu_dst_rob_index     (out_fu_dst_rob_index),
    .out_fu_set_nzcv          (out_fu_set_nzcv),
    .out_fu_nzcv              (out_fu_nzcv)
  );

  always #5 in_clk = ~in_clk;

  // Model entry; the queue order is the age order.
  typedef struct packed {
    logic [3:0]  op;
    logic        a_rdy;
    logic [63:0] a;
    logic [4:0]  a_tag;
    logic        b_rdy;
    logic [63:0] b;
    logic [4:0]  b_tag;
    logic        f_rdy;
    logic [3:0]  f;
    logic [4:0]  f_tag;
    logic        set_f;
    logic [4:0]  dst;
  } m_entry_t;

  m_entry_t mq[$];
  bit       m_disp_rdy = 1'b1;
  int       total = 0;
  int       bad = 0;

  function automatic bit m_ready(input m_entry_t e);
    return e.a_rdy && e.b_rdy && e.f_rdy;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    in_dispatch_valid = 1'b0; in_dispatch_fu_op = FuOpAdd;
    in_dispatch_a_ready = 1'b0; in_dispatch_val_a = '0; in_dispatch_a_tag = '0;
    in_dispatch_b_ready = 1'b0; in_dispatch_val_b = '0; in_dispatch_b_tag = '0;
    in_dispatch_nzcv_ready = 1'b0; in_dispatch_nzcv = '0; in_dispatch_nzcv_tag = '0;
    in_dispatch_set_nzcv = 1'b0; in_dispatch_dst_rob_index = '0;
    in_cdb_valid = 1'b0; in_cdb_rob_index = '0; in_cdb_value = '0;
    in_cdb_set_nzcv = 1'b0; in_cdb_nzcv = '0; in_flush = 1'b0;
  endtask

  task automatic disp(input fu_op_t op, input bit ar, input logic [63:0] a, input int at,
                      input bit br, input logic [63:0] b, input int bt,
                      input bit fr, input logic [3:0] f, input int ft, input bit sf, input int dst);
    in_dispatch_valid = 1'b1; in_dispatch_fu_op = op;
    in_dispatch_a_ready = ar; in_dispatch_val_a = a; in_dispatch_a_tag = 5'(at);
    in_dispatch_b_ready = br; in_dispatch_val_b = b; in_dispatch_b_tag = 5'(bt);
    in_dispatch_nzcv_ready = fr; in_dispatch_nzcv = nzcv_t'(f); in_dispatch_nzcv_tag = 5'(ft);
    in_dispatch_set_nzcv = sf; in_dispatch_dst_rob_index = 5'(dst);
  endtask

  task automatic cdb(input int idx, input logic [63:0] val, input bit sf, input logic [3:0] f);
    in_cdb_valid = 1'b1; in_cdb_rob_index = 5'(idx); in_cdb_value = val;
    in_cdb_set_nzcv = sf; in_cdb_nzcv = nzcv_t'(f);
  endtask

  // Advance one clock: predict from the model, then compare after the edge.
  task automatic tick();
    bit       exp_start;
    bit       rdy_next;
    m_entry_t iss;
    m_entry_t e;
    exp_start = 1'b0;
    iss = '0;
    if (in_flush) begin
      mq.delete();
    end else begin
      if (in_fu_ready) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (m_ready(mq[k])) begin
            iss = mq[k];
            mq.delete(k);
            exp_start = 1'b1;
            break;
          end
        end
      end
      if (in_cdb_valid) begin
        for (int k = 0; k < mq.size(); k++) begin
          e = mq[k];
          if (!e.a_rdy && e.a_tag == in_cdb_rob_index) begin e.a_rdy = 1; e.a = in_cdb_value; end
          if (!e.b_rdy && e.b_tag == in_cdb_rob_index) begin e.b_rdy = 1; e.b = in_cdb_value; end
          if (!e.f_rdy && in_cdb_set_nzcv && e.f_tag == in_cdb_rob_index) begin
            e.f_rdy = 1; e.f = in_cdb_nzcv;
          end
          mq[k] = e;
        end
      end
      if (in_dispatch_valid && m_disp_rdy) begin
        e.op = in_dispatch_fu_op; e.dst = in_dispatch_dst_rob_index; e.set_f = in_dispatch_set_nzcv;
        e.a_rdy = in_dispatch_a_ready; e.a = in_dispatch_val_a; e.a_tag = in_dispatch_a_tag;
        e.b_rdy = in_dispatch_b_ready; e.b = in_dispatch_val_b; e.b_tag = in_dispatch_b_tag;
        e.f_rdy = in_dispatch_nzcv_ready; e.f = in_dispatch_nzcv; e.f_tag = in_dispatch_nzcv_tag;
        if (in_cdb_valid) begin
          if (!e.a_rdy && e.a_tag == in_cdb_rob_index) begin e.a_rdy = 1; e.a = in_cdb_value; end
          if (!e.b_rdy && e.b_tag == in_cdb_rob_index) begin e.b_rdy = 1; e.b = in_cdb_value; end
          if (!e.f_rdy && in_cdb_set_nzcv && e.f_tag == in_cdb_rob_index) begin
            e.f_rdy = 1; e.f = in_cdb_nzcv;
          end
        end
        mq.push_back(e);
      end
    end
    rdy_next = (mq.size() < RS_N);
    @(posedge in_clk);
    #1;
    m_disp_rdy = rdy_next;
    check("fu_start", 64'(out_fu_start), 64'(exp_start));
    check("dispatch_ready", 64'(out_dispatch_ready), 64'(m_disp_rdy));
    if (exp_start) begin
      check("fu_op", 64'(out_fu_op), 64'(iss.op));
      check("fu_val_a", out_fu_val_a, iss.a);
      check("fu_val_b", out_fu_val_b, iss.b);
      check("fu_dst", 64'(out_fu_dst_rob_index), 64'(iss.dst));
      check("fu_set_nzcv", 64'(out_fu_set_nzcv), 64'(iss.set_f));
      check("fu_nzcv", 64'(out_fu_nzcv), 64'(iss.f));
    end
  endtask

  initial begin
    // Reset holds everything idle; dispatch while in reset is ignored.
    idle();
    in_fu_ready = 1'b1;
    in_rst_n = 1'b0;
    disp(FuOpSub, 1, 64'h11, 0, 1, 64'h22, 0, 1, 4'h0, 0, 0, 1);
    repeat (3) @(posedge in_clk);
    #1;
    check("rst_start", 64'(out_fu_start), 64'd0);
    check("rst_disp_ready", 64'(out_dispatch_ready), 64'd1);
    in_rst_n = 1'b1;
    idle();
    repeat (2) tick();

    // Fully-ready op issues two edges after dispatch, single pulse.
    disp(FuOpAdd, 1, 64'd3, 0, 1, 64'd4, 0, 1, 4'h0, 0, 1, 7);
    tick();
    idle();
    tick();
    check("t2_val_a", out_fu_val_a, 64'd3);
    check("t2_val_b", out_fu_val_b, 64'd4);
    tick();

    // Wakeup: B waits on tag 5, issues the edge after the broadcast.
    disp(FuOpOrr, 1, 64'd1, 0, 0, 64'd0, 5, 1, 4'h0, 0, 0, 3);
    tick();
    idle();
    repeat (3) tick();
    cdb(5, 64'd9, 0, 4'h0);
    tick();
    idle();
    tick();
    check("t3_val_b", out_fu_val_b, 64'd9);

    // Fill all slots waiting on tag 2; extra dispatch while full is dropped.
    for (int k = 0; k < RS_N; k++) begin
      disp(FuOpEor, 0, 64'd0, 2, 1, 64'(k), 0, 1, 4'h0, 0, 0, 8 + k);
      tick();
    end
    check("t4_full", 64'(out_dispatch_ready), 64'd0);
    disp(FuOpMov, 1, 64'd0, 0, 1, 64'd0, 0, 1, 4'h0, 0, 0, 20);
    tick();
    idle();
    cdb(2, 64'h77, 0, 4'h0);
    tick();
    idle();
    repeat (RS_N + 1) tick();

    // Backpressure with a same-cycle bypass at dispatch time.
    in_fu_ready = 1'b0;
    disp(FuOpLsl, 0, 64'd0, 6, 1, 64'd2, 0, 0, 4'h0, 6, 1, 12);
    cdb(6, 64'h55, 1, 4'hA);
    tick();
    idle();
    disp(FuOpCmp, 1, 64'hAB, 0, 1, 64'hCD, 0, 1, 4'h3, 0, 1, 13);
    tick();
    idle();
    repeat (2) tick();
    in_fu_ready = 1'b1;
    repeat (3) tick();

    // Flush overrides a same-cycle dispatch and pending issue.
    in_fu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(FuOpAnd, 1, 64'(k), 0, 1, 64'(k), 0, 1, 4'h0, 0, 0, k);
      tick();
    end
    in_fu_ready = 1'b1;
    disp(FuOpAdd, 1, 64'hF, 0, 1, 64'hF, 0, 1, 4'h0, 0, 0, 30);
    in_flush = 1'b1;
    tick();
    idle();
    repeat (3) tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      in_fu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        disp(fu_op_t'($urandom_range(0, 9)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 7),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom_range(0, 31));
      end
      if ($urandom_range(0, 2) != 0) begin
        cdb($urandom_range(0, 7), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'($urandom));
      end
      in_flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    repeat (12) tick();

    // Asynchronous reset mid-operation clears an active issue pulse.
    in_fu_ready = 1'b1;
    disp(FuOpSub, 1, 64'h5, 0, 1, 64'h6, 0, 1, 4'h0, 0, 0, 4);
    tick();
    idle();
    tick();
    in_rst_n = 1'b0;
    #1;
    check("arst_start", 64'(out_fu_start), 64'd0);
    check("arst_disp_ready", 64'(out_dispatch_ready), 64'd1);
    mq.delete();
    m_disp_rdy = 1'b1;
    disp(FuOpMov, 1, 64'h9, 0, 1, 64'h9, 0, 1, 4'h0, 0, 0, 9);
    @(posedge in_clk);
    #1;
    check("arst_no_issue", 64'(out_fu_start), 64'd0);
    in_rst_n = 1'b1;
    idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
